jtdd_gfxrom_server: RTL

//  Responder side of the graphics ROM addr/data/ok interface used by the char, scroll and object layers.

---
 rtl/jtdd_gfxrom_server.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/jtdd_gfxrom_server.sv
// Graphics ROM responder for the char, scroll and object layers: one cached word per
// layer, misses fetched over a single-outstanding SDRAM port with round-robin arbitration.
module jtdd_gfxrom_server #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] SCR_OFFSET  = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h20000
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] char_addr,
  output logic [7:0]  char_data,
  output logic        char_ok,
  input  logic [16:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ok,
  input  logic [18:0] obj_addr,
  output logic [15:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [15:0] sdram_dout
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  localparam logic [1:0] SLOT_CHAR = 2'd0;
  localparam logic [1:0] SLOT_SCR  = 2'd1;
  localparam logic [1:0] SLOT_OBJ  = 2'd2;

  state_t      state;
  logic [1:0]  rr;
  logic [1:0]  gnt;
  logic [18:0] itag;

  logic [14:0] char_tag;
  logic [16:0] scr_tag;
  logic [18:0] obj_tag;
  logic [15:0] char_word, scr_word, obj_word;
  logic        char_vld, scr_vld, obj_vld;

  logic [3:0]  miss;
  logic [1:0]  s0, s1, s2, sel;
  logic [21:0] fetch_addr;
  logic [18:0] fetch_tag;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == SLOT_OBJ) ? SLOT_CHAR : s + 2'd1;
  endfunction

  always_comb begin
    char_ok   = char_vld && (char_addr[15:1] == char_tag);
    scr_ok    = scr_vld  && (scr_addr == scr_tag);
    obj_ok    = obj_vld  && (obj_addr == obj_tag);
    char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
    scr_data  = scr_word;
    obj_data  = obj_word;
    miss      = {1'b0, ~obj_ok, ~scr_ok, ~char_ok};
  end

  // Priority order starts at rr, which always points just past the last granted slot
  always_comb begin
    s0  = rr;
    s1  = next_slot(s0);
    s2  = next_slot(s1);
    sel = miss[s0] ? s0 : (miss[s1] ? s1 : s2);
    fetch_addr = '0;
    fetch_tag  = '0;
    case (sel)
      SLOT_CHAR: begin
        fetch_addr = CHAR_OFFSET + {7'd0, char_addr[15:1]};
        fetch_tag  = {4'd0, char_addr[15:1]};
      end
      SLOT_SCR: begin
        fetch_addr = SCR_OFFSET + {5'd0, scr_addr};
        fetch_tag  = {2'd0, scr_addr};
      end
      default: begin
        fetch_addr = OBJ_OFFSET + {3'd0, obj_addr};
        fetch_tag  = obj_addr;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr         <= SLOT_CHAR;
      gnt        <= SLOT_CHAR;
      itag       <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      char_tag   <= '0;
      scr_tag    <= '0;
      obj_tag    <= '0;
      char_word  <= '0;
      scr_word   <= '0;
      obj_word   <= '0;
      char_vld   <= 1'b0;
      scr_vld    <= 1'b0;
      obj_vld    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (|miss) begin
          gnt        <= sel;
          itag       <= fetch_tag;
          sdram_addr <= fetch_addr;
          sdram_req  <= 1'b1;
          rr         <= next_slot(sel);
          state      <= ST_REQ;
        end
        ST_REQ: if (sdram_ack) begin
          sdram_req <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: if (sdram_dst) begin
          // The issued tag is stored, so a stale fetch lands without raising ok
          case (gnt)
            SLOT_CHAR: begin
              char_tag  <= itag[14:0];
              char_word <= sdram_dout;
              char_vld  <= 1'b1;
            end
            SLOT_SCR: begin
              scr_tag  <= itag[16:0];
              scr_word <= sdram_dout;
              scr_vld  <= 1'b1;
            end
            default: begin
              obj_tag  <= itag;
              obj_word <= sdram_dout;
              obj_vld  <= 1'b1;
            end
          endcase
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
